// File: rtl/rx_pkt_gen_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rx_pkt_gen_sched
//  Brief    : Descriptor-table sequencer for the PHY-emulator RX packet
//             generator. Replays {addr_offset, read_cnt} descriptors as start
//             pulses, waits for each packet to drain at the current fmac_speed,
//             inserts an inter-packet gap, and loops the table a programmable
//             number of times.
//  Revision : 1.0  initial release
// ============================================================================
module rx_pkt_gen_sched #(
    parameter int NUM_DESC  = 8,
    parameter int IPG_BYTES = 12,
    parameter int START_LAT = 4
) (
    input  logic        xaui_clk,
    input  logic        reset_,
    input  logic [1:0]  fmac_speed,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_waddr,
    input  logic [21:0] cfg_wdata,
    input  logic        sched_start,
    input  logic        sched_stop,
    input  logic [2:0]  sched_last,
    input  logic [7:0]  sched_loops,
    output logic        tb_rx_pkt_gen_en,
    output logic [63:0] tb_rx_pkt_gen_addr_offset,
    output logic [10:0] tb_rx_pkt_gen_read_cnt,
    output logic        sched_busy,
    output logic        sched_done,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Cycles per qword at each MAC speed
    localparam logic [9:0] c_MULT_1G   = 10'd8;
    localparam logic [9:0] c_MULT_100M = 10'd80;
    localparam logic [9:0] c_MULT_10M  = 10'd800;

    state_t         state_q, state_d;
    logic [21:0]    desc_q [NUM_DESC];
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     pass_q, pass_d;
    logic [23:0]    timer_q, timer_d;
    logic [9:0]     mult_q, mult_d;
    logic           stop_pend_q, stop_pend_d;
    logic [15:0]    pkt_cnt_q, pkt_cnt_d;
    logic [10:0]    offset_q, offset_d;
    logic [10:0]    rcnt_q, rcnt_d;

    logic [9:0]     w_mult;
    logic [23:0]    w_wait_cycles;
    logic [23:0]    w_gap_cycles;
    logic [7:0]     w_pass_inc;
    logic           w_load;
    logic [2:0]     w_load_idx;

    // Speed decode; the reserved code falls back to the 1G rate so a mid-run
    // change to 00 still yields a finite timer.
    always_comb begin
        w_mult = c_MULT_1G;
        case (fmac_speed)
            2'b10:   w_mult = c_MULT_100M;
            2'b11:   w_mult = c_MULT_10M;
            default: w_mult = c_MULT_1G;
        endcase
    end

    // Drain time covers the whole packet plus the generator start latency; the
    // gap is IPG_BYTES scaled by the speed multiplier latched at issue time.
    assign w_wait_cycles = ({13'd0, rcnt_q} + 24'd1) * {14'd0, w_mult}
                           + 24'(START_LAT) - 24'd1;
    assign w_gap_cycles  = 24'(IPG_BYTES) * {14'd0, mult_q} - 24'd1;
    assign w_pass_inc    = pass_q + 8'd1;

    // Next-state logic for the sequencer and all its counters
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        timer_d     = timer_q;
        mult_d      = mult_q;
        stop_pend_d = stop_pend_q;
        pkt_cnt_d   = pkt_cnt_q;
        offset_d    = offset_q;
        rcnt_d      = rcnt_q;
        w_load      = 1'b0;
        w_load_idx  = idx_q;

        if (sched_stop && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_GAP)) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Start with a valid speed wins over a simultaneous stop
                if (sched_start && fmac_speed != 2'b00) begin
                    state_d     = S_ISSUE;
                    idx_d       = 3'd0;
                    pass_d      = 8'd0;
                    pkt_cnt_d   = 16'd0;
                    stop_pend_d = 1'b0;
                    w_load      = 1'b1;
                    w_load_idx  = 3'd0;
                end
            end
            S_ISSUE: begin
                mult_d  = w_mult;
                timer_d = w_wait_cycles;
                if (pkt_cnt_q != 16'hFFFF) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q == 24'd0) begin
                    timer_d = w_gap_cycles;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            S_GAP: begin
                if (timer_q == 24'd0) begin
                    if (stop_pend_q || sched_stop) begin
                        state_d = S_DONE;
                    end else if (idx_q == sched_last) begin
                        pass_d = w_pass_inc;
                        idx_d  = 3'd0;
                        if (sched_loops != 8'd0 && w_pass_inc == sched_loops) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_ISSUE;
                            w_load     = 1'b1;
                            w_load_idx = 3'd0;
                        end
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        state_d    = S_ISSUE;
                        w_load     = 1'b1;
                        w_load_idx = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            S_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operands are captured on the edge that enters ISSUE and held until
        // the next issue, so they bracket the start pulse on both sides.
        if (w_load) begin
            offset_d = desc_q[w_load_idx][10:0];
            rcnt_d   = desc_q[w_load_idx][21:11];
        end
    end

    // Sequencer state and counter registers
    always_ff @(posedge xaui_clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            pass_q      <= 8'd0;
            timer_q     <= 24'd0;
            mult_q      <= 10'd0;
            stop_pend_q <= 1'b0;
            pkt_cnt_q   <= 16'd0;
            offset_q    <= 11'd0;
            rcnt_q      <= 11'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            timer_q     <= timer_d;
            mult_q      <= mult_d;
            stop_pend_q <= stop_pend_d;
            pkt_cnt_q   <= pkt_cnt_d;
            offset_q    <= offset_d;
            rcnt_q      <= rcnt_d;
        end
    end

    // Descriptor table: writable only while idle so a running replay is never
    // disturbed.
    always_ff @(posedge xaui_clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < NUM_DESC; i++) begin
                desc_q[i] <= 22'd0;
            end
        end else if (cfg_wr && state_q == S_IDLE) begin
            desc_q[cfg_waddr] <= cfg_wdata;
        end
    end

    assign tb_rx_pkt_gen_en          = (state_q == S_ISSUE);
    assign tb_rx_pkt_gen_addr_offset = {53'd0, offset_q};
    assign tb_rx_pkt_gen_read_cnt    = rcnt_q;
    assign sched_busy                = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                                       (state_q == S_GAP);
    assign sched_done                = (state_q == S_DONE);
    assign pkt_cnt                   = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_gen_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_pkt_gen_sched
//  Brief    : Directed self-checking bench for rx_pkt_gen_sched.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rx_pkt_gen_sched;

    logic        xaui_clk = 1'b0;
    logic        reset_   = 1'b0;
    logic [1:0]  fmac_speed  = 2'b01;
    logic        cfg_wr      = 1'b0;
    logic [2:0]  cfg_waddr   = 3'd0;
    logic [21:0] cfg_wdata   = 22'd0;
    logic        sched_start = 1'b0;
    logic        sched_stop  = 1'b0;
    logic [2:0]  sched_last  = 3'd0;
    logic [7:0]  sched_loops = 8'd1;
    logic        tb_rx_pkt_gen_en;
    logic [63:0] tb_rx_pkt_gen_addr_offset;
    logic [10:0] tb_rx_pkt_gen_read_cnt;
    logic        sched_busy;
    logic        sched_done;
    logic [15:0] pkt_cnt;

    rx_pkt_gen_sched u_dut (
        .xaui_clk                  (xaui_clk),
        .reset_                    (reset_),
        .fmac_speed                (fmac_speed),
        .cfg_wr                    (cfg_wr),
        .cfg_waddr                 (cfg_waddr),
        .cfg_wdata                 (cfg_wdata),
        .sched_start               (sched_start),
        .sched_stop                (sched_stop),
        .sched_last                (sched_last),
        .sched_loops               (sched_loops),
        .tb_rx_pkt_gen_en          (tb_rx_pkt_gen_en),
        .tb_rx_pkt_gen_addr_offset (tb_rx_pkt_gen_addr_offset),
        .tb_rx_pkt_gen_read_cnt    (tb_rx_pkt_gen_read_cnt),
        .sched_busy                (sched_busy),
        .sched_done                (sched_done),
        .pkt_cnt                   (pkt_cnt)
    );

    always #5 xaui_clk = ~xaui_clk;

    int          n_vec = 0;
    int          n_err = 0;

    // Start-pulse / done log, sampled on the falling edge
    int          cyc = 0;
    int          n_en = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    int          en_cyc[$];
    logic [10:0] en_off[$];
    logic [10:0] en_cnt[$];

    always @(negedge xaui_clk) begin
        cyc++;
        if (tb_rx_pkt_gen_en) begin
            en_cyc.push_back(cyc);
            en_off.push_back(tb_rx_pkt_gen_addr_offset[10:0]);
            en_cnt.push_back(tb_rx_pkt_gen_read_cnt);
            n_en++;
        end
        if (sched_done) begin
            done_cyc = cyc;
            n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int cyc_at(input int i);
        return (i < en_cyc.size()) ? en_cyc[i] : -1;
    endfunction
    function automatic logic [10:0] off_at(input int i);
        return (i < en_off.size()) ? en_off[i] : 11'h7FF;
    endfunction
    function automatic logic [10:0] cnt_at(input int i);
        return (i < en_cnt.size()) ? en_cnt[i] : 11'h7FF;
    endfunction

    task automatic tick();
        @(posedge xaui_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [10:0] cnt, input logic [10:0] off);
        cfg_wr    = 1'b1;
        cfg_waddr = a;
        cfg_wdata = {cnt, off};
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic pulse_start();
        sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
    endtask

    task automatic pulse_stop();
        sched_stop = 1'b1;
        tick();
        sched_stop = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (n_done > base) ok = 1'b1;
        end
    endtask

    task automatic wait_en(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (n_en >= target) ok = 1'b1;
        end
    endtask

    logic [10:0] exp_off [3] = '{11'd100, 11'd200, 11'd300};
    logic [10:0] exp_cnt [3] = '{11'd3,   11'd0,   11'd5};

    initial begin
        int b_en;
        int b_done;
        bit ok;

        // Reset state
        #12;
        chk("rst_en",     tb_rx_pkt_gen_en, 0);
        chk("rst_busy",   sched_busy, 0);
        chk("rst_done",   sched_done, 0);
        chk("rst_pktcnt", pkt_cnt, 0);
        chk("rst_addr",   tb_rx_pkt_gen_addr_offset, 0);
        chk("rst_rcnt",   tb_rx_pkt_gen_read_cnt, 0);
        tick();
        reset_ = 1'b1;
        tick();

        // 1G single packet: 1 issue + 68 wait + 96 gap
        cfg_write(3'd0, 11'd7, 11'd16);
        fmac_speed = 2'b01; sched_last = 3'd0; sched_loops = 8'd1;
        b_en = n_en; b_done = n_done;
        pulse_start();
        tick();
        chk("t1_busy_run", sched_busy, 1);
        wait_done(b_done, 400, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_npkt", n_en - b_en, 1);
        chk("t1_off", off_at(b_en), 16);
        chk("t1_cnt", cnt_at(b_en), 7);
        chk("t1_lat", done_cyc - cyc_at(b_en), 165);
        chk("t1_pktcnt", pkt_cnt, 1);
        chk("t1_addr64", tb_rx_pkt_gen_addr_offset, 64'd16);
        tick();
        chk("t1_busy_end", sched_busy, 0);

        // 100M: wait 644, gap 960
        fmac_speed = 2'b10;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 2000, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_npkt", n_en - b_en, 1);
        chk("t2_lat", done_cyc - cyc_at(b_en), 1605);
        tick();

        // Three descriptors, three passes
        for (int i = 0; i < 3; i++) cfg_write(3'(i), exp_cnt[i], exp_off[i]);
        fmac_speed = 2'b01; sched_last = 3'd2; sched_loops = 8'd3;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 3000, ok);
        chk("t3_done_seen", ok, 1);
        chk("t3_npkt", n_en - b_en, 9);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t3_off%0d", k), off_at(b_en + k), exp_off[k % 3]);
        end
        chk("t3_cnt8", cnt_at(b_en + 8), exp_cnt[2]);
        chk("t3_pktcnt", pkt_cnt, 9);
        tick();

        // Endless loop, busy-time cfg/start ignored, stop mid-WAIT of packet 5
        sched_loops = 8'd0;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_en(b_en + 5, 2000, ok);
        chk("t4_pkt5_seen", ok, 1);
        cfg_write(3'd1, 11'd9, 11'd999);
        pulse_start();
        pulse_stop();
        wait_done(b_done, 500, ok);
        chk("t4_done_seen", ok, 1);
        chk("t4_npkt", n_en - b_en, 5);
        chk("t4_pktcnt", pkt_cnt, 5);
        chk("t4_lat", done_cyc - cyc_at(b_en + 4), 109);
        tick();

        // Table unchanged by the busy-time write
        sched_last = 3'd1; sched_loops = 8'd1;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 600, ok);
        chk("t5_done_seen", ok, 1);
        chk("t5_off1", off_at(b_en + 1), 200);
        chk("t5_cnt1", cnt_at(b_en + 1), 0);
        tick();

        // Start with reserved speed ignored
        fmac_speed = 2'b00;
        b_en = n_en;
        pulse_start();
        tick();
        chk("t6_busy_spd0", sched_busy, 0);
        chk("t6_npkt_spd0", n_en - b_en, 0);

        // Stop in IDLE must not leak into the next run
        fmac_speed = 2'b01;
        pulse_stop();
        sched_last = 3'd0; sched_loops = 8'd2;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 600, ok);
        chk("t6_done_seen", ok, 1);
        chk("t6_npkt", n_en - b_en, 2);
        chk("t6_pktcnt", pkt_cnt, 2);
        tick();

        // Reset during WAIT
        sched_loops = 8'd0;
        b_en = n_en;
        pulse_start();
        wait_en(b_en + 1, 50, ok);
        chk("t7_en_seen", ok, 1);
        tick(); tick(); tick();
        reset_ = 1'b0;
        #1;
        chk("t7_rst_busy",   sched_busy, 0);
        chk("t7_rst_en",     tb_rx_pkt_gen_en, 0);
        chk("t7_rst_pktcnt", pkt_cnt, 0);
        chk("t7_rst_addr",   tb_rx_pkt_gen_addr_offset, 0);
        chk("t7_rst_rcnt",   tb_rx_pkt_gen_read_cnt, 0);
        b_en = n_en;
        tick(); tick();
        chk("t7_no_en_in_rst", n_en - b_en, 0);
        reset_ = 1'b1;
        tick();

        // Table cleared by reset: descriptor 0 now {0,0}
        sched_loops = 8'd1;
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 400, ok);
        chk("t8_done_seen", ok, 1);
        chk("t8_off", off_at(b_en), 0);
        chk("t8_lat", done_cyc - cyc_at(b_en), 109);
        tick();

        // Normal restart after reset
        cfg_write(3'd0, 11'd7, 11'd16);
        b_en = n_en; b_done = n_done;
        pulse_start();
        wait_done(b_done, 400, ok);
        chk("t9_done_seen", ok, 1);
        chk("t9_off", off_at(b_en), 16);
        chk("t9_lat", done_cyc - cyc_at(b_en), 165);
        chk("t9_pktcnt", pkt_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
